// File: rtl/pri_enc_seq_if.sv
// Request/grant bundle for pri_enc_seq: load/req/ready in,
// valid/idx/pending/count out.
interface pri_enc_seq_if #(
  parameter int N = 8,
  parameter int W = $clog2(N)
);
  logic         load;
  logic [N-1:0] req;
  logic         ready;
  logic         valid;
  logic [W-1:0] idx;
  logic [N-1:0] pending;
  logic [W:0]   count;

  modport master (
    output load, req, ready,
    input  valid, idx, pending, count
  );

  modport slave (
    input  load, req, ready,
    output valid, idx, pending, count
  );
endinterface

// File: rtl/pri_enc_seq.sv
// Pending-request register with fixed or round-robin
// priority encoding of the next index to service.
module pri_enc_seq #(
  parameter int N      = 8,
  parameter int W      = $clog2(N),
  parameter int ROTATE = 0
) (
  input logic          clk,
  input logic          rst,
  pri_enc_seq_if.slave bus
);

  logic [N-1:0] pend;
  logic [N-1:0] pend_nxt;
  logic [N-1:0] clr;
  logic [W-1:0] ptr;
  logic [W-1:0] ptr_nxt;
  logic [W-1:0] fx_sel;
  logic [W-1:0] rr_sel;
  logic [W-1:0] sel;
  logic [W:0]   j;
  logic [W:0]   cnt;
  logic         any;
  logic         acc;

  always_comb begin
    fx_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (pend[i]) fx_sel = W'(i);
    end
  end

  // Scan offsets high to low so the nearest bit above ptr wins.
  always_comb begin
    rr_sel = '0;
    j      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = {1'b0, ptr} + (W+1)'(k);
      if (j >= (W+1)'(N)) j = j - (W+1)'(N);
      if (pend[j[W-1:0]]) rr_sel = j[W-1:0];
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + (W+1)'(pend[i]);
    end
  end

  always_comb begin
    sel      = (ROTATE != 0) ? rr_sel : fx_sel;
    any      = |pend;
    acc      = any & bus.ready;
    clr      = acc ? ((N)'(1) << sel) : '0;
    pend_nxt = (pend & ~clr) | (bus.load ? bus.req : '0);
    ptr_nxt  = ptr;
    if ((ROTATE != 0) && acc) begin
      ptr_nxt = (sel == W'(N - 1)) ? '0 : sel + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      ptr  <= '0;
    end else begin
      pend <= pend_nxt;
      ptr  <= ptr_nxt;
    end
  end

  assign bus.valid   = any;
  assign bus.idx     = any ? sel : '0;
  assign bus.pending = pend;
  assign bus.count   = cnt;

endmodule

// File: tb/tb_pri_enc_seq.sv
// Directed bench for pri_enc_seq: fixed and round-robin
// N=8 instances plus a round-robin N=5 instance.
module tb_pri_enc_seq;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  pri_enc_seq_if #(.N(8)) bf ();
  pri_enc_seq_if #(.N(8)) br ();
  pri_enc_seq_if #(.N(5)) b5 ();

  pri_enc_seq #(.N(8), .ROTATE(0)) u_fx (
    .clk(clk), .rst(rst), .bus(bf)
  );
  pri_enc_seq #(.N(8), .ROTATE(1)) u_rr (
    .clk(clk), .rst(rst), .bus(br)
  );
  pri_enc_seq #(.N(5), .ROTATE(1)) u_r5 (
    .clk(clk), .rst(rst), .bus(b5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    n_cmp++;
    if ({bf.valid, bf.idx, bf.count, bf.pending} !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_fx: got %h want 0000",
               {bf.valid, bf.idx, bf.count, bf.pending});
    end
    n_cmp++;
    if ({br.valid, br.idx, br.count, br.pending} !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_rr: got %h want 0000",
               {br.valid, br.idx, br.count, br.pending});
    end
    n_cmp++;
    if ({b5.valid, b5.idx, b5.count, b5.pending} !== 13'h0) begin
      n_bad++;
      $display("FAIL reset_n5: got %h want 0000",
               {b5.valid, b5.idx, b5.count, b5.pending});
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_fixed;
    logic [2:0] ei [4];
    ei = '{3'd7, 3'd4, 3'd2, 3'd1};
    bf.req   = 8'b1001_0110;
    bf.load  = 1'b1;
    bf.ready = 1'b1;
    tick;
    bf.load = 1'b0;
    bf.req  = '0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({bf.valid, bf.idx, bf.count} !== {1'b1, ei[i], 4'(4 - i)}) begin
        n_bad++;
        $display("FAIL fixed_step%0d: got %h want %h", i,
                 {bf.valid, bf.idx, bf.count}, {1'b1, ei[i], 4'(4 - i)});
      end
      tick;
    end
    n_cmp++;
    if ({bf.valid, bf.idx, bf.count} !== 8'h00) begin
      n_bad++;
      $display("FAIL fixed_empty: got %h want 00",
               {bf.valid, bf.idx, bf.count});
    end
    bf.ready = 1'b0;
  endtask

  task automatic test_round_robin;
    logic [2:0] ei [3];
    ei = '{3'd0, 3'd1, 3'd7};
    br.req   = 8'b1000_0011;
    br.load  = 1'b1;
    br.ready = 1'b1;
    tick;
    br.load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({br.valid, br.idx, br.count} !== {1'b1, ei[i], 4'(3 - i)}) begin
        n_bad++;
        $display("FAIL rr_step%0d: got %h want %h", i,
                 {br.valid, br.idx, br.count}, {1'b1, ei[i], 4'(3 - i)});
      end
      tick;
    end
    n_cmp++;
    if ({br.valid, br.idx, br.count} !== 8'h00) begin
      n_bad++;
      $display("FAIL rr_empty: got %h want 00",
               {br.valid, br.idx, br.count});
    end
    // ptr must have wrapped to 0: bit 0 beats bit 7
    br.ready = 1'b0;
    br.req   = 8'b1000_0001;
    br.load  = 1'b1;
    tick;
    br.load = 1'b0;
    n_cmp++;
    if ({br.valid, br.idx, br.count} !== {1'b1, 3'd0, 4'd2}) begin
      n_bad++;
      $display("FAIL rr_wrap: got %h want %h",
               {br.valid, br.idx, br.count}, {1'b1, 3'd0, 4'd2});
    end
    br.ready = 1'b1;
    tick;
    n_cmp++;
    if ({br.valid, br.idx, br.count} !== {1'b1, 3'd7, 4'd1}) begin
      n_bad++;
      $display("FAIL rr_after0: got %h want %h",
               {br.valid, br.idx, br.count}, {1'b1, 3'd7, 4'd1});
    end
    tick;
    br.ready = 1'b0;
    br.req   = 8'b0000_0001;
    br.load  = 1'b1;
    tick;
    br.load = 1'b0;
    n_cmp++;
    if ({br.valid, br.idx, br.count} !== {1'b1, 3'd0, 4'd1}) begin
      n_bad++;
      $display("FAIL rr_reload: got %h want %h",
               {br.valid, br.idx, br.count}, {1'b1, 3'd0, 4'd1});
    end
    br.ready = 1'b1;
    tick;
    n_cmp++;
    if (br.pending !== 8'h00) begin
      n_bad++;
      $display("FAIL rr_drain: got %h want 00", br.pending);
    end
    br.ready = 1'b0;
  endtask

  task automatic test_simultaneous;
    bf.req   = 8'b0000_0100;
    bf.load  = 1'b1;
    bf.ready = 1'b0;
    tick;
    n_cmp++;
    if ({bf.valid, bf.idx, bf.pending} !== {1'b1, 3'd2, 8'h04}) begin
      n_bad++;
      $display("FAIL sim_load: got %h want %h",
               {bf.valid, bf.idx, bf.pending}, {1'b1, 3'd2, 8'h04});
    end
    bf.ready = 1'b1;
    tick;
    bf.load = 1'b0;
    n_cmp++;
    if ({bf.valid, bf.idx, bf.pending} !== {1'b1, 3'd2, 8'h04}) begin
      n_bad++;
      $display("FAIL sim_setclr: got %h want %h",
               {bf.valid, bf.idx, bf.pending}, {1'b1, 3'd2, 8'h04});
    end
    tick;
    n_cmp++;
    if ({bf.valid, bf.pending} !== 9'h000) begin
      n_bad++;
      $display("FAIL sim_clear: got %h want 000",
               {bf.valid, bf.pending});
    end
    bf.ready = 1'b0;
  endtask

  task automatic test_backpressure;
    bf.req   = 8'b0011_0000;
    bf.load  = 1'b1;
    bf.ready = 1'b0;
    tick;
    bf.load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({bf.valid, bf.idx, bf.count} !== {1'b1, 3'd5, 4'd2}) begin
        n_bad++;
        $display("FAIL hold%0d: got %h want %h", i,
                 {bf.valid, bf.idx, bf.count}, {1'b1, 3'd5, 4'd2});
      end
      tick;
    end
    bf.ready = 1'b1;
    tick;
    n_cmp++;
    if ({bf.valid, bf.idx, bf.count} !== {1'b1, 3'd4, 4'd1}) begin
      n_bad++;
      $display("FAIL hold_release: got %h want %h",
               {bf.valid, bf.idx, bf.count}, {1'b1, 3'd4, 4'd1});
    end
    tick;
    bf.ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    bf.req   = 8'hff;
    bf.load  = 1'b1;
    bf.ready = 1'b1;
    tick;
    bf.load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if ({bf.valid, bf.idx, bf.count} !== {1'b1, 3'(7 - i), 4'(8 - i)}) begin
        n_bad++;
        $display("FAIL b2b_step%0d: got %h want %h", i,
                 {bf.valid, bf.idx, bf.count}, {1'b1, 3'(7 - i), 4'(8 - i)});
      end
      tick;
    end
    n_cmp++;
    if ({bf.valid, bf.count} !== 5'h00) begin
      n_bad++;
      $display("FAIL b2b_empty: got %h want 00", {bf.valid, bf.count});
    end
    bf.ready = 1'b0;
  endtask

  task automatic test_npot;
    b5.req   = 5'b01000;
    b5.load  = 1'b1;
    b5.ready = 1'b1;
    tick;
    n_cmp++;
    if ({b5.valid, b5.idx, b5.count} !== {1'b1, 3'd3, 4'd1}) begin
      n_bad++;
      $display("FAIL n5_first: got %h want %h",
               {b5.valid, b5.idx, b5.count}, {1'b1, 3'd3, 4'd1});
    end
    b5.req = 5'b10001;
    tick;
    b5.load = 1'b0;
    n_cmp++;
    if ({b5.idx, b5.pending} !== {3'd4, 5'b10001}) begin
      n_bad++;
      $display("FAIL n5_idx4: got %h want %h",
               {b5.idx, b5.pending}, {3'd4, 5'b10001});
    end
    tick;
    n_cmp++;
    if ({b5.valid, b5.idx, b5.pending} !== {1'b1, 3'd0, 5'b00001}) begin
      n_bad++;
      $display("FAIL n5_wrap: got %h want %h",
               {b5.valid, b5.idx, b5.pending}, {1'b1, 3'd0, 5'b00001});
    end
    tick;
    b5.req  = 5'b11111;
    b5.load = 1'b1;
    tick;
    b5.load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({b5.valid, b5.idx, b5.count} !==
          {1'b1, 3'((i + 1) % 5), 4'(5 - i)}) begin
        n_bad++;
        $display("FAIL n5_full%0d: got %h want %h", i,
                 {b5.valid, b5.idx, b5.count},
                 {1'b1, 3'((i + 1) % 5), 4'(5 - i)});
      end
      tick;
    end
    n_cmp++;
    if ({b5.valid, b5.idx, b5.count} !== 8'h00) begin
      n_bad++;
      $display("FAIL n5_empty: got %h want 00",
               {b5.valid, b5.idx, b5.count});
    end
    b5.ready = 1'b0;
  endtask

  task automatic test_async_reset;
    bf.req   = 8'hf0;
    bf.load  = 1'b1;
    bf.ready = 1'b1;
    tick;
    bf.load = 1'b0;
    tick;
    n_cmp++;
    if ({bf.valid, bf.idx, bf.count} !== {1'b1, 3'd6, 4'd3}) begin
      n_bad++;
      $display("FAIL ar_pre: got %h want %h",
               {bf.valid, bf.idx, bf.count}, {1'b1, 3'd6, 4'd3});
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bf.valid, bf.idx, bf.count, bf.pending} !== 16'h0) begin
      n_bad++;
      $display("FAIL ar_immediate: got %h want 0000",
               {bf.valid, bf.idx, bf.count, bf.pending});
    end
    bf.req  = 8'hff;
    bf.load = 1'b1;
    tick;
    n_cmp++;
    if ({bf.valid, bf.pending} !== 9'h000) begin
      n_bad++;
      $display("FAIL ar_ignore_load: got %h want 000",
               {bf.valid, bf.pending});
    end
    rst      = 1'b0;
    bf.ready = 1'b0;
    bf.req   = 8'b0000_1000;
    tick;
    bf.load = 1'b0;
    n_cmp++;
    if ({bf.valid, bf.idx, bf.count} !== {1'b1, 3'd3, 4'd1}) begin
      n_bad++;
      $display("FAIL ar_after: got %h want %h",
               {bf.valid, bf.idx, bf.count}, {1'b1, 3'd3, 4'd1});
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    bf.load = 1'b0; bf.req = '0; bf.ready = 1'b0;
    br.load = 1'b0; br.req = '0; br.ready = 1'b0;
    b5.load = 1'b0; b5.req = '0; b5.ready = 1'b0;
    test_reset;
    test_fixed;
    test_round_robin;
    test_simultaneous;
    test_backpressure;
    test_back_to_back;
    test_npot;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
